// File: rtl/fp16_to_int16_if.sv
// Valid/ready stream bundle for the fp16 -> int16 converter: operand side in, result side out.
// The slave modport is the converter's view; the master modport is the producer/consumer view.
interface fp16_to_int16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        out_inv;
    logic        out_inexact;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ovf,
        output out_inv,
        output out_inexact
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ovf,
        input  out_inv,
        input  out_inexact
    );
endinterface

// File: rtl/fp16_to_int16.sv
// Two-stage binary16 to signed int16 converter, truncating toward zero, with saturation
// and NaN/overflow/inexact flags. Elastic valid/ready pipeline, throughput one per cycle.
module fp16_to_int16 (
    input  logic           clk,
    input  logic           rst,
    fp16_to_int16_if.slave bus
);

    typedef struct packed {
        logic signed [15:0] data;
        logic               ovf;
        logic               inv;
        logic               inex;
    } result_t;

    function automatic logic signed [15:0] f_saturate(input logic sign);
        return sign ? 16'sh8000 : 16'sh7FFF;
    endfunction

    function automatic logic signed [15:0] f_negate(input logic sign, input logic [15:0] mag);
        logic signed [15:0] v;
        v = $signed(mag);
        return sign ? -v : v;
    endfunction

    // Truncating conversion of a decoded operand; flags are mutually exclusive by construction.
    function automatic result_t f_convert(
        input logic        sign,
        input logic [4:0]  exp,
        input logic [10:0] sig,
        input logic        nan,
        input logic        inf,
        input logic        zero
    );
        result_t     r;
        logic [15:0] mag;
        logic [10:0] mask;
        logic [4:0]  sh;
        r    = '0;
        mag  = '0;
        mask = '0;
        sh   = '0;
        if (nan) begin
            r.inv = 1'b1;
        end else if (inf) begin
            r.ovf  = 1'b1;
            r.data = f_saturate(sign);
        end else if (exp == 5'd30) begin
            if (sign && (sig[9:0] == 10'd0)) begin
                r.data = 16'sh8000;
            end else begin
                r.ovf  = 1'b1;
                r.data = f_saturate(sign);
            end
        end else if (exp >= 5'd25) begin
            sh     = exp - 5'd25;
            mag    = {5'b0, sig} << sh;
            r.data = f_negate(sign, mag);
        end else if (exp >= 5'd15) begin
            sh     = 5'd25 - exp;
            mag    = {5'b0, sig} >> sh;
            mask   = (11'h1 << sh) - 11'h1;
            r.inex = |(sig & mask);
            r.data = f_negate(sign, mag);
        end else if (exp != 5'd0) begin
            r.inex = 1'b1;
        end else begin
            r.inex = ~zero;
        end
        return r;
    endfunction

    logic        w_adv1;
    logic        w_adv2;
    logic        w_sign;
    logic [4:0]  w_exp;
    logic [9:0]  w_frac;
    result_t     w_res;

    logic        r_vld_p1;
    logic        r_sign_p1;
    logic [4:0]  r_exp_p1;
    logic [10:0] r_sig_p1;
    logic        r_nan_p1;
    logic        r_inf_p1;
    logic        r_zero_p1;

    logic               r_vld_p2;
    logic signed [15:0] r_data_p2;
    logic               r_ovf_p2;
    logic               r_inv_p2;
    logic               r_inex_p2;

    assign w_adv2 = ~r_vld_p2 | bus.out_ready;
    assign w_adv1 = ~r_vld_p1 | w_adv2;
    assign bus.in_ready = w_adv1;

    assign w_sign = bus.in_data[15];
    assign w_exp  = bus.in_data[14:10];
    assign w_frac = bus.in_data[9:0];

    // Stage 1: decode fields and classify the operand
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_adv1) begin
            r_vld_p1 <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv1 && bus.in_valid) begin
            r_sign_p1 <= w_sign;
            r_exp_p1  <= w_exp;
            r_sig_p1  <= {(w_exp != 5'd0), w_frac};
            r_nan_p1  <= (w_exp == 5'd31) && (w_frac != 10'd0);
            r_inf_p1  <= (w_exp == 5'd31) && (w_frac == 10'd0);
            r_zero_p1 <= (w_exp == 5'd0) && (w_frac == 10'd0);
        end
    end

    assign w_res = f_convert(r_sign_p1, r_exp_p1, r_sig_p1, r_nan_p1, r_inf_p1, r_zero_p1);

    // Stage 2: shift, saturate, negate; output registers clear on reset so the port reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_ovf_p2  <= 1'b0;
            r_inv_p2  <= 1'b0;
            r_inex_p2 <= 1'b0;
        end else if (w_adv2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= w_res.data;
                r_ovf_p2  <= w_res.ovf;
                r_inv_p2  <= w_res.inv;
                r_inex_p2 <= w_res.inex;
            end
        end
    end

    assign bus.out_valid   = r_vld_p2;
    assign bus.out_data    = r_data_p2;
    assign bus.out_ovf     = r_ovf_p2;
    assign bus.out_inv     = r_inv_p2;
    assign bus.out_inexact = r_inex_p2;

endmodule

// File: doc/fp16_to_int16.md
FP16_TO_INT16 -- requirements
Module: fp16_to_int16

Interface
REQ-001 The block SHALL have no parameters; the input is fixed binary16 and the output is a fixed 16-bit signed two's-complement integer.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on the clk rising edge.
REQ-004 in_valid  input  1  in_data holds an operand.
REQ-005 in_ready  output  1  the block accepts the operand this cycle.
REQ-006 in_data  input  16  binary16 operand: bit 15 sign, bits 14:10 exponent (bias 15), bits 9:0 fraction.
REQ-007 out_valid  output  1  out_data and the flags are valid.
REQ-008 out_ready  input  1  the consumer takes the result this cycle.
REQ-009 out_data  output  16  signed int16 result.
REQ-010 out_ovf  output  1  the result saturated (|x| too large, or infinity).
REQ-011 out_inv  output  1  the operand was NaN.
REQ-012 out_inexact  output  1  nonzero fraction bits were discarded by truncation.

Function
REQ-013 Transfers SHALL occur only on cycles where valid and ready are both high: input (in_valid & in_ready), output (out_valid & out_ready).
REQ-014 The pipeline SHALL have two register stages (S1 decode, S2 shift/saturate/negate); with out_ready held high, the result SHALL appear exactly 2 cycles after acceptance, at a throughput of 1 per cycle.
REQ-015 Stage advance: adv2 = ~out_valid | out_ready; adv1 = ~s1_valid | adv2; in_ready = adv1, a combinational path with no dependency on in_valid.
REQ-016 While out_valid=1 and out_ready=0, out_data and all three flags SHALL hold stable, and no accepted operand SHALL be lost or duplicated.
REQ-017 S1 SHALL register the sign, the 5-bit exponent E, the 11-bit significand {E!=0, F}, and the NaN/Inf/zero classification.
REQ-018 Rounding SHALL truncate toward zero.
REQ-019 Conversion for E=0 (zero or subnormal): result 0; inexact = (F!=0).
REQ-020 Conversion for 1<=E<=14: result 0; inexact = 1.
REQ-021 Conversion for 15<=E<=24: magnitude = {1,F} >> (25-E); inexact = (any shifted-out bit is nonzero).
REQ-022 Conversion for 25<=E<=29: magnitude = {1,F} << (E-25), held in at least 15 bits; inexact = 0.
REQ-023 Conversion for E=30, sign=1, F=0: result 0x8000 with no flags set.
REQ-024 Conversion for E=30 in all other cases: saturate to 0x7FFF (positive) or 0x8000 (negative); ovf = 1.
REQ-025 Conversion for E=31, F=0 (infinity): saturate by sign as in REQ-024; ovf = 1.
REQ-026 Conversion for E=31, F!=0 (NaN): result 0x0000; inv = 1; ovf = 0; inexact = 0.
REQ-027 For non-saturated results, a negative sign SHALL produce the two's complement of the magnitude; -0 and negative values that truncate to 0 SHALL give 0x0000.
REQ-028 Only one of ovf and inv SHALL be set per result; inexact SHALL be 0 whenever ovf or inv is 1.

Reset
REQ-029 On a clock edge with rst=1, s1_valid and out_valid SHALL clear to 0 and any in-flight operands SHALL be discarded.
REQ-030 In the cycle after reset, out_data SHALL be 0x0000 and out_ovf, out_inv and out_inexact SHALL be 0.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-032 An operand presented on the same edge as rst=1 SHALL NOT be accepted.

Verification
REQ-033 Basic values, out_ready=1: 0x3C00 -> 0x0001 at cycle+2, flags 0; 0xC500 -> 0xFFFB, flags 0.
REQ-034 Truncation: 0x3E00 (1.5) -> 0x0001, inexact=1; 0xBE00 (-1.5) -> 0xFFFF, inexact=1; 0x3800 (0.5) -> 0x0000, inexact=1; 0x8000 -> 0x0000, flags 0.
REQ-035 Limits: 0x7BFF (65504) -> 0x7FFF, ovf=1; 0xF800 (-32768) -> 0x8000, flags 0; 0xFC00 (-Inf) -> 0x8000, ovf=1; 0x7E00 (NaN) -> 0x0000, inv=1.
REQ-036 Backpressure: stream 0x4000, 0x4200, 0x4400 with out_ready=0 for 4 cycles.
REQ-036 required response: in_ready drops after 2 accepts; out_data holds 0x0002; after out_ready rises, 0x0002, 0x0003, 0x0004 are delivered in order with none dropped.
REQ-037 Reset mid-operation: rst=1 for one cycle with both stages full -> out_valid=0 next cycle, and the flushed results never appear.
REQ-038 Exponent sweep: E=15..30 with F=0x3FF, positive and negative, compared against a reference truncation model, including the 24/25 shift boundary.
